// File: rtl/ft_alu_pkg.sv
// Shared op encodings, two-rail codes and FSM states for the fault-tolerant ALU pipe.
package ft_alu_pkg;

  localparam logic [2:0] OP_ADD    = 3'b001;
  localparam logic [2:0] OP_SUB_AB = 3'b010;
  localparam logic [2:0] OP_SUB_BA = 3'b100;

  localparam logic [1:0] TR_OK  = 2'b10;
  localparam logic [1:0] TR_ERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    RETRY = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // 2-of-3 majority vote for the triplicated input checkers
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/ft_alu_copy.sv
// One datapath copy: operand select/negate feeding a WIDTH-bit ripple adder.
module ft_alu_copy
  import ft_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ctrl,
  input  logic             flip,
  output logic [WIDTH-1:0] sum_c,
  output logic             carry_c
);

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] s;
  logic             c;

  // ~v+1 is folded into the adder as inverted operand plus carry-in, so
  // carry-out reads as "no borrow" even when the negated operand is zero.
  always_comb begin
    opa = a;
    opb = b;
    c   = 1'b0;
    case (ctrl)
      OP_SUB_AB: begin
        opb = ~b;
        c   = 1'b1;
      end
      OP_SUB_BA: begin
        opa = b;
        opb = ~a;
        c   = 1'b1;
      end
      default: ;
    endcase
    s = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      s[i] = opa[i] ^ opb[i] ^ c;
      c    = (opa[i] & opb[i]) | (c & (opa[i] ^ opb[i]));
    end
    sum_c   = s ^ WIDTH'(flip);
    carry_c = c;
  end

endmodule

// File: rtl/ft_alu_pipe.sv
// Duplicated add/subtract unit with copy comparison, bounded retry and two-rail error codes.
module ft_alu_pipe
  import ft_alu_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RETRY_MAX = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             par,
  input  logic [2:0]       ctrl,
  input  logic             fi_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             xc,
  output logic             yc,
  output logic [1:0]       xe,
  output logic [1:0]       ye,
  output logic [1:0]       retry_cnt,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  localparam int unsigned RCW = $clog2(RETRY_MAX + 2);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             par_q, par_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [RCW-1:0]   rtry_q, rtry_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic             xc_q, xc_d, yc_q, yc_d;
  logic [1:0]       xe_q, xe_d, ye_q, ye_d;
  logic [1:0]       retry_cnt_q, retry_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] sum_x, sum_y;
  logic             cx, cy;
  logic [2:0]       par_ok_v, oh_ok_v;
  logic             in_err;
  logic             eq_xt, eq_xf, eq_yt, eq_yf;
  logic [1:0]       code_x, code_y;

  ft_alu_copy #(.WIDTH(WIDTH)) u_copy_x (
    .a(a_q), .b(b_q), .ctrl(ctrl_q), .flip(1'b0), .sum_c(sum_x), .carry_c(cx)
  );

  ft_alu_copy #(.WIDTH(WIDTH)) u_copy_y (
    .a(a_q), .b(b_q), .ctrl(ctrl_q), .flip(fi_en), .sum_c(sum_y), .carry_c(cy)
  );

  // Triplicated parity and one-hot checkers on the held operands
  for (genvar i = 0; i < 3; i++) begin : g_chk
    assign par_ok_v[i] = ^{a_q, b_q, par_q};
    assign oh_ok_v[i]  = (ctrl_q == OP_ADD) | (ctrl_q == OP_SUB_AB) | (ctrl_q == OP_SUB_BA);
  end

  assign in_err = ~maj3(par_ok_v) | ~maj3(oh_ok_v);

  // Each side owns a true-rail and a complement-rail comparator
  assign eq_xt  = (sum_x == sum_y) && (cx == cy);
  assign eq_xf  = (sum_x == sum_y) && (cx == cy);
  assign eq_yt  = (sum_y == sum_x) && (cy == cx);
  assign eq_yf  = (sum_y == sum_x) && (cy == cx);
  assign code_x = {eq_xt, ~eq_xf};
  assign code_y = {eq_yt, ~eq_yf};

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    par_d       = par_q;
    ctrl_d      = ctrl_q;
    rtry_d      = rtry_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    x_d         = x_q;
    y_d         = y_q;
    xc_d        = xc_q;
    yc_d        = yc_q;
    xe_d        = xe_q;
    ye_d        = ye_q;
    retry_cnt_d = retry_cnt_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d         = a;
          b_d         = b;
          par_d       = par;
          ctrl_d      = ctrl;
          rtry_d      = '0;
          retry_cnt_d = 2'd0;
          in_ready_d  = 1'b0;
          state_d     = EXEC;
        end
      end
      EXEC, RETRY: begin
        if ((eq_xt && eq_yt) || in_err || (rtry_q >= RCW'(RETRY_MAX))) begin
          x_d         = sum_x;
          y_d         = sum_y;
          xc_d        = cx;
          yc_d        = cy;
          xe_d        = (in_err || !(eq_xt && eq_yt)) ? TR_ERR : code_x;
          ye_d        = (in_err || !(eq_xt && eq_yt)) ? TR_ERR : code_y;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          rtry_d      = rtry_q + RCW'(1);
          retry_cnt_d = (retry_cnt_q == 2'd3) ? retry_cnt_q : retry_cnt_q + 2'd1;
          state_d     = RETRY;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear wins over a same-cycle error handshake
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (out_valid_q && out_ready && ((xe_q != TR_OK) || (ye_q != TR_OK))
                 && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      par_q       <= 1'b0;
      ctrl_q      <= 3'd0;
      rtry_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      xc_q        <= 1'b0;
      yc_q        <= 1'b0;
      xe_q        <= TR_OK;
      ye_q        <= TR_OK;
      retry_cnt_q <= 2'd0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      par_q       <= par_d;
      ctrl_q      <= ctrl_d;
      rtry_q      <= rtry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      xc_q        <= xc_d;
      yc_q        <= yc_d;
      xe_q        <= xe_d;
      ye_q        <= ye_d;
      retry_cnt_q <= retry_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign x         = x_q;
  assign y         = y_q;
  assign xc        = xc_q;
  assign yc        = yc_q;
  assign xe        = xe_q;
  assign ye        = ye_q;
  assign retry_cnt = retry_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ft_alu_pipe.sv
// Directed-vector bench for ft_alu_pipe with hand-computed expectations.
module tb_ft_alu_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       par = 1'b0;
  logic [2:0] ctrl = 3'b000;
  logic       fi_en = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] x, y;
  logic       xc, yc;
  logic [1:0] xe, ye;
  logic [1:0] retry_cnt;
  logic [7:0] err_cnt;
  logic       err_clr = 1'b0;

  int total = 0;
  int bad = 0;
  int exp_err = 0;
  int lat;

  ft_alu_pipe #(.WIDTH(8), .RETRY_MAX(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .par(par), .ctrl(ctrl), .fi_en(fi_en),
    .out_valid(out_valid), .out_ready(out_ready), .x(x), .y(y),
    .xc(xc), .yc(yc), .xe(xe), .ye(ye), .retry_cnt(retry_cnt),
    .err_cnt(err_cnt), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one beat and wait (bounded) for out_valid; fmode 1 = fault only in EXEC, 2 = held
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ip,
                       input logic [2:0] ic, input int fmode, output int l);
    a = ia; b = ib; par = ip; ctrl = ic; in_valid = 1'b1;
    fi_en = (fmode == 2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    l = 1;
    if (fmode == 1) fi_en = 1'b1;
    while (!out_valid && l < 20) begin
      @(posedge clk); #1;
      l++;
      fi_en = (fmode == 2);
    end
    check("out_valid_seen", 32'(out_valid), 32'(1));
  endtask

  task automatic retire(input string tag, input logic err_code);
    out_ready = 1'b1;
    if (err_code && exp_err < 255) exp_err++;
    @(posedge clk); #1;
    out_ready = 1'b0;
    fi_en = 1'b0;
    check({tag, "_ov_low"}, 32'(out_valid), 32'(0));
    check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
  endtask

  task automatic run_vec(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                         input logic ip, input logic [2:0] ic, input int fmode,
                         input logic chk_data, input logic [7:0] ex, input logic [7:0] ey,
                         input logic ec, input logic [1:0] ee, input int elat,
                         input logic [1:0] erc);
    int l;
    issue(ia, ib, ip, ic, fmode, l);
    check({tag, "_lat"}, 32'(l), 32'(elat));
    if (chk_data) begin
      check({tag, "_x"}, 32'(x), 32'(ex));
      check({tag, "_y"}, 32'(y), 32'(ey));
      check({tag, "_xc"}, 32'(xc), 32'(ec));
      check({tag, "_yc"}, 32'(yc), 32'(ec));
    end
    check({tag, "_xe"}, 32'(xe), 32'(ee));
    check({tag, "_ye"}, 32'(ye), 32'(ee));
    check({tag, "_retry_cnt"}, 32'(retry_cnt), 32'(erc));
    check({tag, "_busy"}, 32'(in_ready), 32'(0));
    retire(tag, ee != 2'b10);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_x", 32'(x), 32'(0));
    check("rst_xe", 32'(xe), 32'(2'b10));
    check("rst_ye", 32'(ye), 32'(2'b10));
    check("rst_err_cnt", 32'(err_cnt), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    //       tag        a      b      p     ctrl    f  data  x      y      c     e      lat rc
    run_vec("add",     8'h05, 8'h03, 1'b1, 3'b001, 0, 1'b1, 8'h08, 8'h08, 1'b0, 2'b10, 2, 2'd0);
    run_vec("sub_ab",  8'h05, 8'h03, 1'b1, 3'b010, 0, 1'b1, 8'h02, 8'h02, 1'b1, 2'b10, 2, 2'd0);
    run_vec("sub_ba",  8'h05, 8'h03, 1'b1, 3'b100, 0, 1'b1, 8'hFE, 8'hFE, 1'b0, 2'b10, 2, 2'd0);
    run_vec("add_ovf", 8'hFF, 8'h01, 1'b0, 3'b001, 0, 1'b1, 8'h00, 8'h00, 1'b1, 2'b10, 2, 2'd0);
    run_vec("sub_b0",  8'h05, 8'h00, 1'b1, 3'b010, 0, 1'b1, 8'h05, 8'h05, 1'b1, 2'b10, 2, 2'd0);
    run_vec("par_err", 8'h05, 8'h03, 1'b0, 3'b001, 0, 1'b1, 8'h08, 8'h08, 1'b0, 2'b11, 2, 2'd0);
    run_vec("ctrl011", 8'h05, 8'h03, 1'b1, 3'b011, 0, 1'b0, 8'h00, 8'h00, 1'b0, 2'b11, 2, 2'd0);
    run_vec("ctrl000", 8'h05, 8'h03, 1'b1, 3'b000, 0, 1'b0, 8'h00, 8'h00, 1'b0, 2'b11, 2, 2'd0);
    run_vec("fault1",  8'h05, 8'h03, 1'b1, 3'b001, 1, 1'b1, 8'h08, 8'h08, 1'b0, 2'b10, 3, 2'd1);
    run_vec("faultP",  8'h05, 8'h03, 1'b1, 3'b001, 2, 1'b0, 8'h00, 8'h00, 1'b0, 2'b11, 4, 2'd2);
    check("faultP_x_last", 32'(x), 32'(8'h08));
    check("faultP_y_last", 32'(y), 32'(8'h09));

    // Backpressure: result must hold for five stalled cycles
    issue(8'h05, 8'h03, 1'b1, 3'b001, 0, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_x", 32'(x), 32'(8'h08));
      check("bp_out_valid", 32'(out_valid), 32'(1));
      check("bp_in_ready", 32'(in_ready), 32'(0));
    end
    retire("bp", 1'b0);

    // Asynchronous reset while retrying
    a = 8'h05; b = 8'h03; par = 1'b1; ctrl = 3'b001; in_valid = 1'b1; fi_en = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'(0));
    check("rst_mid_err_cnt", 32'(err_cnt), 32'(0));
    check("rst_mid_in_ready", 32'(in_ready), 32'(1));
    fi_en = 1'b0;
    exp_err = 0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_out_valid", 32'(out_valid), 32'(0));

    // Drive the error counter to saturation
    for (int i = 0; i < 255; i++) begin
      issue(8'h05, 8'h03, 1'b0, 3'b001, 0, lat);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    exp_err = 255;
    check("sat_err_cnt", 32'(err_cnt), 32'(8'hFF));
    run_vec("sat_more", 8'h05, 8'h03, 1'b0, 3'b001, 0, 1'b1, 8'h08, 8'h08, 1'b0, 2'b11, 2, 2'd0);

    // Clear beats a simultaneous error handshake
    issue(8'h05, 8'h03, 1'b0, 3'b001, 0, lat);
    err_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    out_ready = 1'b0;
    exp_err = 0;
    check("clr_prio_err_cnt", 32'(err_cnt), 32'(0));
    run_vec("after_clr", 8'h05, 8'h03, 1'b1, 3'b001, 0, 1'b1, 8'h08, 8'h08, 1'b0, 2'b10, 2, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ft_alu_pipe.md
Name: ft_alu_pipe

Overview:
- Parametrised, pipelined successor to the 3-bit fault-tolerant add/subtract unit.
- Accepts WIDTH-bit operands A and B, a parity bit over both, and a one-hot operation select. Computes the result on two independent datapath copies and compares them.
- Mismatches between copies are retried on held operands up to RETRY_MAX times before an error is reported.
- Results are presented on duplicated X/Y output channels, each with a two-rail error code and a valid/ready handshake. It sits between the operand-source register file and the result writeback.

Parameters:
- WIDTH, 8, operand and result width in bits (min 2).
- RETRY_MAX, 2, maximum recompute attempts after a copy mismatch (0 = no retry).
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- par  in  1  parity bit; XOR of {a,b,par} must equal 1 (odd parity).
- ctrl  in  3  one-hot op select: [0] A+B, [1] A-B, [2] B-A.
- fi_en  in  1  fault-injection hook for verification; while high, inverts bit 0 of copy-Y sum. Tie to 0 in product.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- x, y  out  WIDTH each  result sums from copy X and copy Y.
- xc, yc  out  1 each  carry-out from copy X and copy Y.
- xe, ye  out  2 each  two-rail code. 2'b10 = ok; 2'b11 = detected error; any other value = checker fault.
- retry_cnt  out  2  retries consumed by the current result.
- err_cnt  out  CNT_W  saturating count of results delivered with an error code.
- err_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset:
  - State IDLE; in_ready=1, out_valid=0.
  - x, y, xc, yc, retry_cnt and err_cnt reset to 0; xe and ye reset to 2'b10.
  - Reset mid-operation discards the held beat; no partial output is driven.
- FSM states: IDLE, EXEC, RETRY, HOLD.
  - IDLE: in_ready=1. Transfer on in_valid&in_ready latches a, b, par and ctrl into the operand register, then goes to EXEC.
  - EXEC/RETRY: in_ready=0. Both copies compute from the operand register, using separate negate logic and separate ripple adders.
    - If the copies agree, or an input error exists: register outputs, go to HOLD, assert out_valid next cycle.
    - If sums or carries mismatch and retries < RETRY_MAX: increment retry_cnt, go to RETRY (recompute next cycle).
    - If mismatch and retries == RETRY_MAX: register outputs with xe=ye=2'b11, go to HOLD.
  - HOLD: outputs stable while out_valid=1 and out_ready=0. On out_ready, go to IDLE. in_ready rises the cycle after the handshake.
- Latency: 2 cycles from accept to out_valid with no retries; +1 per retry. One beat outstanding at a time.
- Arithmetic:
  - Two's-complement negate = ~v+1 on the selected operand.
  - Sum is WIDTH bits; carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - For subtraction, carry=1 means no borrow.
- Input errors:
  - Parity failure, or ctrl not exactly one-hot (including 000), forces xe=ye=2'b11.
  - No retry is attempted; the result is still computed and delivered.
  - Each input checker is triplicated with a 2-of-3 voter.
- Error code generation:
  - xe is generated from the X-side comparator and ye from the Y-side comparator, as dual-rail complements.
  - If a comparator's two rails disagree, the code is not 10 and is reported as-is.
- err_cnt:
  - Increments on each output handshake where xe!=2'b10 or ye!=2'b10.
  - Saturates at all-ones.
  - err_clr has priority over increment in the same cycle.
- x and y are not voted; the consumer compares them.

Decomposition:
- Shared package ft_alu_pkg holds:
  - op encoding constants OP_ADD=3'b001, OP_SUB_AB=3'b010, OP_SUB_BA=3'b100;
  - two-rail constants TR_OK=2'b10, TR_ERR=2'b11;
  - the FSM state enum.
- One natural sub-module: ft_alu_copy (negate + WIDTH-bit adder + carry), instantiated twice. The checkers stay inline.

Test Plan:
- Add: a=0x05, b=0x03, par=1, ctrl=001 -> x=y=0x08, xc=yc=0, xe=ye=10, out_valid 2 cycles after accept, retry_cnt=0.
- Subtract: a=0x05, b=0x03, par=1, ctrl=010 -> x=y=0x02, carry=1. Same operands with ctrl=100 -> x=y=0xFE, carry=0. All with xe=ye=10.
- Input errors: par=0 with a=0x05, b=0x03 -> xe=ye=11, no retry, err_cnt +1. ctrl=011 -> xe=ye=11. ctrl=000 -> xe=ye=11.
- Single-cycle fault: fi_en high only in EXEC -> one retry, result 0x08 with ok code at cycle 3, retry_cnt=1, err_cnt unchanged.
- Persistent fault: fi_en held high -> after 2 retries, x=0x08, y=0x09, xe=ye=11 at cycle 4, err_cnt +1.
- Backpressure and reset: out_ready=0 for 5 cycles -> outputs stable, in_ready=0. rst_n low during RETRY -> out_valid=0 and err_cnt=0 immediately. err_cnt=0xFF with an error handshake -> stays 0xFF.
